jtkunio_objbuf: RTL and testbench

//  Double-buffered object line buffer, directly upstream of the colour mixer.
//  The object renderer hands over 8-pixel object rows through a valid/ready port.

---
 rtl/jtkunio_pkg.sv | 33 +++
 rtl/jtframe_dual_ram.sv | 29 ++
 rtl/jtkunio_objbuf.sv | 191 +++++++++++++++++++
 tb/tb_jtkunio_objbuf.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_pkg.sv
// Shared constants, state encoding and pixel helper for the jtkunio object line buffer.
package jtkunio_pkg;

   localparam int         ROW_PIXELS = 8;
   localparam int         OBJ_BPP    = 3;
   localparam logic [5:0] OBJ_BLANK  = 6'd0;

   typedef enum logic {
      IDLE = 1'b0,
      DRAW = 1'b1
   } objbuf_state_t;

   // Extract pixel idx (0..7) from a packed 8 x 3bpp object row.
   function automatic logic [OBJ_BPP-1:0] row_pixel(
      input logic [ROW_PIXELS*OBJ_BPP-1:0] data,
      input logic [2:0]                    idx
   );
      logic [OBJ_BPP-1:0] pix;
      case (idx)
         3'd0:    pix = data[2:0];
         3'd1:    pix = data[5:3];
         3'd2:    pix = data[8:6];
         3'd3:    pix = data[11:9];
         3'd4:    pix = data[14:12];
         3'd5:    pix = data[17:15];
         3'd6:    pix = data[20:18];
         3'd7:    pix = data[23:21];
         default: pix = 3'd0;
      endcase
      return pix;
   endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port 0 is write-only, port 1 reads (registered) and may write the same address.
module jtframe_dual_ram #(
   parameter int aw = 9,
   parameter int dw = 6
) (
   input  logic          clk,
   input  logic [aw-1:0] addr0,
   input  logic [dw-1:0] data0,
   input  logic          we0,
   input  logic [aw-1:0] addr1,
   input  logic [dw-1:0] data1,
   input  logic          we1,
   output logic [dw-1:0] q1
);

   logic [dw-1:0] mem_q [0:(1<<aw)-1];

   // Both write ports and the port-1 registered read (old data on read-while-write)
   always_ff @(posedge clk) begin
      if (we0) begin
         mem_q[addr0] <= data0;
      end
      if (we1) begin
         mem_q[addr1] <= data1;
      end
      q1 <= mem_q[addr1];
   end

endmodule

// File: rtl/jtkunio_objbuf.sv
// Double-buffered object line buffer: rows are unpacked into the draw bank while the
// display bank is scanned at pixel rate and erased behind the read.
module jtkunio_objbuf
   import jtkunio_pkg::*;
#(
   parameter logic [7:0] HOFFSET = 8'd0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pxl_cen,
   input  logic                           LHBL,
   input  logic [7:0]                     hdump,
   input  logic                           row_valid,
   output logic                           row_ready,
   input  logic [7:0]                     row_x,
   input  logic [2:0]                     row_pal,
   input  logic                           row_hflip,
   input  logic [ROW_PIXELS*OBJ_BPP-1:0]  row_data,
   output logic                           overrun,
   output logic [5:0]                     obj_pxl
);

   objbuf_state_t                  state_q;
   logic [2:0]                     cnt_q;
   logic [8:0]                     x9_q;
   logic [2:0]                     pal_q;
   logic                           hflip_q;
   logic [ROW_PIXELS*OBJ_BPP-1:0]  data_q;
   logic                           row_ready_q;
   logic                           overrun_q;

   logic                           bank_q;
   logic                           bank_d;
   logic                           lhbl_q;

   logic                           rd_pend_q;
   logic [8:0]                     scan_addr_q;
   logic [5:0]                     pix_hold_q;
   logic [5:0]                     obj_pxl_q;

   logic                           swap_s;
   logic [8:0]                     row_x9_s;
   logic [2:0]                     pix_idx_s;
   logic [OBJ_BPP-1:0]             pix_s;
   logic [8:0]                     col_s;
   logic                           draw_we_s;
   logic [8:0]                     draw_addr_s;
   logic [5:0]                     draw_din_s;
   logic [8:0]                     scan_ram_addr_s;
   logic [5:0]                     scan_q_s;

   assign row_ready = row_ready_q;
   assign overrun   = overrun_q;
   assign obj_pxl   = obj_pxl_q;

   assign swap_s      = lhbl_q & ~LHBL;
   assign row_x9_s    = {1'b0, row_x} + {1'b0, HOFFSET};
   assign col_s       = x9_q + {6'd0, cnt_q};
   assign pix_s       = row_pixel(data_q, pix_idx_s);
   assign draw_addr_s = {~bank_q, col_s[7:0]};
   assign draw_din_s  = {pal_q, pix_s};

   // Pixel order within the row and the bank toggle on the LHBL falling edge
   always_comb begin
      pix_idx_s = cnt_q;
      bank_d    = bank_q;
      if (hflip_q) begin
         pix_idx_s = 3'd7 - cnt_q;
      end else begin
         pix_idx_s = cnt_q;
      end
      if (swap_s) begin
         bank_d = ~bank_q;
      end else begin
         bank_d = bank_q;
      end
   end

   // Draw write enable: opaque pixel, on-screen column, and not the swap cycle
   always_comb begin
      draw_we_s = 1'b0;
      if ((state_q == DRAW) && (pix_s != 3'd0) && !col_s[8] && !swap_s) begin
         draw_we_s = 1'b1;
      end else begin
         draw_we_s = 1'b0;
      end
   end

   // Scan port address: new column when idle, held address during the erase cycle
   always_comb begin
      scan_ram_addr_s = {bank_q, hdump};
      if (rd_pend_q) begin
         scan_ram_addr_s = scan_addr_q;
      end else begin
         scan_ram_addr_s = {bank_q, hdump};
      end
   end

   // Row draw FSM: accept a request, then spend exactly one clk per pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         x9_q        <= 9'd0;
         pal_q       <= 3'd0;
         hflip_q     <= 1'b0;
         data_q      <= '0;
         row_ready_q <= 1'b1;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               row_ready_q <= 1'b1;
               if (row_valid && row_ready_q) begin
                  x9_q        <= row_x9_s;
                  pal_q       <= row_pal;
                  hflip_q     <= row_hflip;
                  data_q      <= row_data;
                  cnt_q       <= 3'd0;
                  row_ready_q <= 1'b0;
                  state_q     <= DRAW;
               end
            end
            DRAW: begin
               if (swap_s) begin
                  // Line swap cuts the row short; the rest is lost
                  state_q     <= IDLE;
                  row_ready_q <= 1'b1;
                  overrun_q   <= 1'b1;
               end else if (cnt_q == 3'(ROW_PIXELS - 1)) begin
                  state_q     <= IDLE;
                  row_ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            default: begin
               state_q     <= IDLE;
               row_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // LHBL edge history and display bank select
   always_ff @(posedge clk) begin
      if (rst) begin
         lhbl_q <= 1'b0;
         bank_q <= 1'b0;
      end else begin
         lhbl_q <= LHBL;
         bank_q <= bank_d;
      end
   end

   // Scan pipeline: read on pxl_cen, capture and erase next clk, present on next pxl_cen
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q   <= 1'b0;
         scan_addr_q <= 9'd0;
         pix_hold_q  <= OBJ_BLANK;
         obj_pxl_q   <= OBJ_BLANK;
      end else begin
         if (rd_pend_q) begin
            pix_hold_q <= scan_q_s;
            rd_pend_q  <= 1'b0;
         end else if (pxl_cen && LHBL) begin
            scan_addr_q <= {bank_q, hdump};
            rd_pend_q   <= 1'b1;
         end
         if (pxl_cen) begin
            obj_pxl_q <= LHBL ? pix_hold_q : OBJ_BLANK;
         end
      end
   end

   jtframe_dual_ram #(
      .aw (9),
      .dw (6)
   ) u_ram (
      .clk   (clk),
      .addr0 (draw_addr_s),
      .data0 (draw_din_s),
      .we0   (draw_we_s),
      .addr1 (scan_ram_addr_s),
      .data1 (OBJ_BLANK),
      .we1   (rd_pend_q),
      .q1    (scan_q_s)
   );

endmodule

// File: tb/tb_jtkunio_objbuf.sv
// Scoreboard bench for jtkunio_objbuf: scan stimulus queues expected obj_pxl values,
// a monitor pops and compares one entry per pxl_cen.
module tb_jtkunio_objbuf;

   logic        clk = 1'b0;
   logic        rst;
   logic        pxl_cen;
   logic        LHBL;
   logic [7:0]  hdump;
   logic        row_valid;
   logic        row_ready;
   logic [7:0]  row_x;
   logic [2:0]  row_pal;
   logic        row_hflip;
   logic [23:0] row_data;
   logic        overrun;
   logic [5:0]  obj_pxl;

   always #5 clk = ~clk;

   jtkunio_objbuf #(.HOFFSET(8'd0)) dut (
      .clk       (clk),
      .rst       (rst),
      .pxl_cen   (pxl_cen),
      .LHBL      (LHBL),
      .hdump     (hdump),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_x     (row_x),
      .row_pal   (row_pal),
      .row_hflip (row_hflip),
      .row_data  (row_data),
      .overrun   (overrun),
      .obj_pxl   (obj_pxl)
   );

   typedef struct {
      bit         chk;
      logic [5:0] exp;
      int         col;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [5:0] exp_line [0:255];
   logic [5:0] hold_m = 6'd0;
   bit         hold_ok = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input bit chk, input logic [5:0] e, input int col);
      exp_t t;
      t.chk = chk;
      t.exp = e;
      t.col = col;
      sb_q.push_back(t);
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 256; i++) exp_line[i] = 6'd0;
   endtask

   // Active scan of ncols columns; a full line ends with the LHBL fall.
   // With late set, a row is requested so that the swap hits it after 3 pixels.
   task automatic scan_line(input bit chk, input int ncols, input bit late,
                            input logic [7:0] lx, input logic [2:0] lpal, input logic [23:0] ldata);
      for (int h = 0; h < ncols; h++) begin
         @(negedge clk);
         pxl_cen = 1'b1;
         LHBL    = 1'b1;
         hdump   = h[7:0];
         push(chk && hold_ok, hold_m, h - 1);
         hold_m  = exp_line[h];
         hold_ok = chk;
         if (late && h == 254) begin
            check("late_ready_pre", {31'd0, row_ready}, 32'd1);
            row_x     = lx;
            row_pal   = lpal;
            row_hflip = 1'b0;
            row_data  = ldata;
            row_valid = 1'b1;
         end
         @(negedge clk);
         pxl_cen   = 1'b0;
         row_valid = 1'b0;
      end
      if (ncols == 256) begin
         @(negedge clk);
         pxl_cen = 1'b1;
         LHBL    = 1'b0;
         push(1'b1, 6'd0, -1);
         @(negedge clk);
         pxl_cen = 1'b0;
         if (late) check("abort_idle_ready", {31'd0, row_ready}, 32'd1);
         clear_exp();
      end
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pxl_cen = 1'b1;
         LHBL    = 1'b0;
         push(1'b1, 6'd0, -1);
         @(negedge clk);
         pxl_cen = 1'b0;
      end
   endtask

   task automatic draw_row(input string name, input logic [7:0] x, input logic [2:0] pal,
                           input logic hf, input logic [23:0] data);
      int n;
      @(negedge clk);
      check({name, "_ready_idle"}, {31'd0, row_ready}, 32'd1);
      row_x     = x;
      row_pal   = pal;
      row_hflip = hf;
      row_data  = data;
      row_valid = 1'b1;
      @(negedge clk);
      row_valid = 1'b0;
      n = 0;
      while (row_ready === 1'b0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({name, "_busy_clks"}, n, 32'd8);
   endtask

   // Monitor: one expected entry per pxl_cen edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (pxl_cen === 1'b1) begin
            #1;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scan_underflow: got %h expected none", obj_pxl);
            end else begin
               e = sb_q.pop_front();
               if (e.chk) begin
                  checks++;
                  if (obj_pxl !== e.exp) begin
                     errors++;
                     $display("FAIL scan col %0d: got %h expected %h", e.col, obj_pxl, e.exp);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; hdump = 8'd0; row_valid = 1'b0;
      row_x = 8'd0; row_pal = 3'd0; row_hflip = 1'b0; row_data = 24'd0;
      clear_exp();
      repeat (2) @(negedge clk);
      check("rst_row_ready", {31'd0, row_ready}, 32'd1);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_obj_pxl", {26'd0, obj_pxl}, 32'd0);
      rst = 1'b0;

      // Erase both banks (RAM is not cleared by reset)
      blank(2); scan_line(1'b0, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2); scan_line(1'b0, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Row x=10 pal=5 pixels {1,2,3,0,4,5,6,7}
      draw_row("t1", 8'd10, 3'd5, 1'b0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2, 3'd1});
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);
      exp_line[10] = 6'h29; exp_line[11] = 6'h2A; exp_line[12] = 6'h2B; exp_line[13] = 6'h00;
      exp_line[14] = 6'h2C; exp_line[15] = 6'h2D; exp_line[16] = 6'h2E; exp_line[17] = 6'h2F;
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Same row mirrored
      draw_row("t2", 8'd10, 3'd5, 1'b1, {3'd7, 3'd6, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2, 3'd1});
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);
      exp_line[10] = 6'h2F; exp_line[11] = 6'h2E; exp_line[12] = 6'h2D; exp_line[13] = 6'h2C;
      exp_line[14] = 6'h00; exp_line[15] = 6'h2B; exp_line[16] = 6'h2A; exp_line[17] = 6'h29;
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Right-edge clip: x=252, pal=2, all pixels 3; cols 0..3 stay empty
      draw_row("t3", 8'd252, 3'd2, 1'b0, 24'o33333333);
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);
      exp_line[252] = 6'h13; exp_line[253] = 6'h13; exp_line[254] = 6'h13; exp_line[255] = 6'h13;
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Read twice: the bank just shown must come back empty two swaps later
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Row cut short by the line swap after 3 pixels
      check("t5_overrun_pre", {31'd0, overrun}, 32'd0);
      scan_line(1'b1, 256, 1'b1, 8'd100, 3'd1, 24'o77777777);
      check("t5_overrun", {31'd0, overrun}, 32'd1);
      check("t5_row_ready", {31'd0, row_ready}, 32'd1);
      blank(2);
      exp_line[100] = 6'h0F; exp_line[101] = 6'h0F; exp_line[102] = 6'h0F;
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Reset mid-line and mid-DRAW while an opaque pixel is on obj_pxl
      draw_row("t6", 8'd20, 3'd3, 1'b0, 24'o55555555);
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);
      for (int i = 20; i < 28; i++) exp_line[i] = 6'h1D;
      scan_line(1'b1, 26, 1'b0, 8'd0, 3'd0, 24'd0);
      @(negedge clk);
      row_x = 8'd0; row_pal = 3'd0; row_hflip = 1'b0; row_data = 24'd0; row_valid = 1'b1;
      @(negedge clk);
      row_valid = 1'b0;
      check("t6_busy_pre_rst", {31'd0, row_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_row_ready", {31'd0, row_ready}, 32'd1);
      check("t6_rst_obj_pxl", {26'd0, obj_pxl}, 32'd0);
      check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      clear_exp();
      hold_ok = 1'b0;
      hold_m  = 6'd0;
      blank(2); scan_line(1'b0, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2); scan_line(1'b0, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      // Normal operation after reset: mirrored single pixel lands at x
      draw_row("t7", 8'd200, 3'd7, 1'b1, {3'd1, 21'd0});
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);
      exp_line[200] = 6'h39;
      scan_line(1'b1, 256, 1'b0, 8'd0, 3'd0, 24'd0);
      blank(2);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
